// File: rtl/soc_arb_pkg.sv
// soc_arb_pkg: shared limits and types for the peripheral bus arbiter
package soc_arb_pkg;
  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_MAX_LATENCY = 8;
  typedef logic [2:0] arb_idx_t;
  typedef struct packed {
    logic     valid;
    arb_idx_t owner;
  } arb_stage_t;
endpackage

// File: rtl/soc_rr_arbiter.sv
// soc_rr_arbiter: round-robin winner search, rr pointer and optional grant lock
// Lock hold is compiled in only when SOC_ARB_LOCK_EN is defined.
module soc_rr_arbiter
  import soc_arb_pkg::*;
#(
  parameter int REQ_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [REQ_COUNT-1:0] req,
  input  logic [REQ_COUNT-1:0] req_lock,
  output logic                 gnt_any,
  output arb_idx_t             win,
  output logic [REQ_COUNT-1:0] gnt
);
  arb_idx_t ptr_q, ptr_d;
  logic [REQ_COUNT-1:0] elig;
  logic [REQ_COUNT-1:0] rot;
  logic found;
`ifdef SOC_ARB_LOCK_EN
  logic lock_q, lock_d;
  arb_idx_t lock_idx_q;
  // A locked owner excludes everyone else, even while it is idle
  assign elig = lock_q ? req & (REQ_COUNT'(1) << lock_idx_q) : req;
  assign lock_d = |(req_lock & gnt);
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= win;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign elig = req;
`endif
  // Rotate so bit 0 is the pointer position; the lowest set bit wins
  always_comb begin
    rot   = REQ_COUNT'({elig, elig} >> ptr_q);
    win   = '0;
    found = 1'b0;
    for (int j = REQ_COUNT - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win   = arb_idx_t'((int'(ptr_q) + j >= REQ_COUNT) ? int'(ptr_q) + j - REQ_COUNT : int'(ptr_q) + j);
        found = 1'b1;
      end
    end
  end
  assign gnt_any = found & res_n;
  assign gnt     = gnt_any ? REQ_COUNT'(1) << win : '0;
  assign ptr_d   = gnt_any ? ((win == arb_idx_t'(REQ_COUNT - 1)) ? '0 : win + 1'b1) : ptr_q;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/soc_periph_arbiter.sv
// soc_periph_arbiter: shares one fixed-latency peripheral slave among REQ_COUNT masters
// Define SOC_ARB_LOCK_EN to let req_lock hold the grant on one requester.
module soc_periph_arbiter
  import soc_arb_pkg::*;
#(
  parameter int BUS_LATENCY = 1,
  parameter int REQ_COUNT   = 2
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [REQ_COUNT-1:0]    req,
  input  logic [REQ_COUNT-1:0]    req_we,
  input  logic [32*REQ_COUNT-1:0] req_addr,
  input  logic [32*REQ_COUNT-1:0] req_wdata,
  input  logic [4*REQ_COUNT-1:0]  req_wstrb,
  input  logic [REQ_COUNT-1:0]    req_lock,
  output logic [REQ_COUNT-1:0]    gnt,
  output logic [REQ_COUNT-1:0]    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    bus_valid,
  output logic                    bus_we,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  output logic [3:0]              bus_wstrb,
  input  logic [31:0]             bus_rdata
);
  logic gnt_any;
  arb_idx_t win;
  arb_stage_t [BUS_LATENCY-1:0] pipe_q, pipe_d;
  soc_rr_arbiter #(.REQ_COUNT(REQ_COUNT)) u_arb (
    .clk      (clk),
    .res_n    (res_n),
    .req      (req),
    .req_lock (req_lock),
    .gnt_any  (gnt_any),
    .win      (win),
    .gnt      (gnt)
  );
  assign bus_valid = gnt_any;
  // One-hot AND-OR mux leaves the bus at zero when nothing is granted
  always_comb begin
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      bus_we    = bus_we | (gnt[i] & req_we[i]);
      bus_addr  = bus_addr | (gnt[i] ? req_addr[32*i +: 32] : 32'h0);
      bus_wdata = bus_wdata | (gnt[i] ? req_wdata[32*i +: 32] : 32'h0);
      bus_wstrb = bus_wstrb | (gnt[i] ? req_wstrb[4*i +: 4] : 4'h0);
    end
  end
  always_comb begin
    pipe_d[0] = arb_stage_t'{valid: gnt_any, owner: win};
    for (int i = 1; i < BUS_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign rsp_valid = pipe_q[BUS_LATENCY-1].valid ? REQ_COUNT'(1) << pipe_q[BUS_LATENCY-1].owner : '0;
  assign rsp_rdata = bus_rdata;
endmodule

// File: tb/tb_soc_periph_arbiter.sv
// tb_soc_periph_arbiter: directed stimulus with a response scoreboard, REQ_COUNT=3, BUS_LATENCY=2
module tb_soc_periph_arbiter;
  localparam int N = 3;
  localparam int L = 2;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic [N-1:0] req = '0, req_we = '0, req_lock = '0;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [4*N-1:0] req_wstrb;
  logic [N-1:0] gnt, rsp_valid;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
  logic bus_valid, bus_we;
  logic [3:0] bus_wstrb;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [N-1:0] own;
    int           due;
    bit           rd;
  } exp_t;
  exp_t q[$];
  exp_t e;
  soc_periph_arbiter #(.BUS_LATENCY(L), .REQ_COUNT(N)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus_rdata = 32'hCAFE0000 + 32'(cyc);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask
  task automatic exp_gnt(input logic [N-1:0] g, input string nm);
    int idx;
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(g));
    chk({nm, "_bvalid"}, 32'(bus_valid), 32'(g != 0));
    if (g == 0) begin
      chk({nm, "_baddr_idle"}, bus_addr, 0);
      chk({nm, "_bwdata_idle"}, bus_wdata, 0);
      chk({nm, "_bwe_idle"}, 32'({bus_we, bus_wstrb}), 0);
    end else begin
      idx = 0;
      for (int i = 0; i < N; i++) if (g[i]) idx = i;
      chk({nm, "_baddr"}, bus_addr, req_addr[32*idx +: 32]);
      chk({nm, "_bwe"}, 32'(bus_we), 32'(req_we[idx]));
      if (req_we[idx]) begin
        chk({nm, "_bwdata"}, bus_wdata, req_wdata[32*idx +: 32]);
        chk({nm, "_bwstrb"}, 32'(bus_wstrb), 32'(req_wstrb[4*idx +: 4]));
      end
      q.push_back('{own: g, due: cyc + L, rd: !req_we[idx]});
    end
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] we, input logic [N-1:0] lk,
                      input logic [N-1:0] g, input string nm);
    @(negedge clk);
    req = r;
    req_we = we;
    req_lock = lk;
    exp_gnt(g, nm);
  endtask
  // Scoreboard monitor: every response must match the oldest outstanding grant
  always @(negedge clk) begin
    #2;
    if (rsp_valid !== '0) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        e = q.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(e.own));
        chk("rsp_cycle", cyc, e.due);
        if (e.rd) chk("rsp_rdata", rsp_rdata, 32'hCAFE0000 + 32'(e.due));
      end
    end
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32]  = 32'h10 + 32'h100 * i;
      req_wdata[32*i +: 32] = 32'h1134 + 32'h100 * i;
    end
    req_wstrb = 12'b1111_0011_1111;
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_bvalid", 32'(bus_valid), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    req = 3'b111;
    #1;
    chk("rst_force_gnt", 32'(gnt), 0);
    chk("rst_force_bvalid", 32'(bus_valid), 0);
    @(negedge clk);
    req = '0;
    res_n = 1'b1;
    step(3'b111, 3'b000, 3'b000, 3'b001, "rr0");
    step(3'b111, 3'b000, 3'b000, 3'b010, "rr1");
    step(3'b111, 3'b000, 3'b000, 3'b100, "rr2");
    step(3'b111, 3'b000, 3'b000, 3'b001, "rr_wrap");
    step(3'b001, 3'b000, 3'b000, 3'b001, "single");
    step(3'b000, 3'b000, 3'b000, 3'b000, "idle");
    step(3'b001, 3'b000, 3'b000, 3'b001, "pipe0");
    step(3'b010, 3'b000, 3'b000, 3'b010, "pipe1");
    step(3'b001, 3'b000, 3'b000, 3'b001, "pipe2");
    step(3'b010, 3'b010, 3'b000, 3'b010, "wr");
`ifdef SOC_ARB_LOCK_EN
    step(3'b011, 3'b000, 3'b001, 3'b001, "lk0");
    step(3'b011, 3'b000, 3'b001, 3'b001, "lk1");
    step(3'b011, 3'b000, 3'b001, 3'b001, "lk2");
    step(3'b011, 3'b000, 3'b000, 3'b001, "lk_rel");
    step(3'b011, 3'b000, 3'b000, 3'b010, "lk_after");
`else
    step(3'b011, 3'b000, 3'b001, 3'b001, "nolk0");
    step(3'b011, 3'b000, 3'b001, 3'b010, "nolk1");
    step(3'b011, 3'b000, 3'b001, 3'b001, "nolk2");
    step(3'b011, 3'b000, 3'b000, 3'b010, "nolk3");
    step(3'b011, 3'b000, 3'b000, 3'b001, "nolk4");
`endif
    step(3'b000, 3'b000, 3'b000, 3'b000, "idle2");
    step(3'b001, 3'b000, 3'b000, 3'b001, "pre_rst");
    @(negedge clk);
    res_n = 1'b0;
    req = 3'b111;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_bvalid", 32'(bus_valid), 0);
    q.delete();
    @(negedge clk);
    #1;
    chk("midrst_rsp_t2", 32'(rsp_valid), 0);
    chk("midrst_gnt_t2", 32'(gnt), 0);
    res_n = 1'b1;
    exp_gnt(3'b001, "post_rst");
    step(3'b111, 3'b000, 3'b000, 3'b010, "post1");
    step(3'b111, 3'b000, 3'b000, 3'b100, "post2");
    step(3'b000, 3'b000, 3'b000, 3'b000, "idle3");
    repeat (L + 2) @(negedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
